// File: rtl/a_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is presented on o_data_out
// whenever the queue is non-empty. Full and empty come straight from the registered pointers.
module a_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_write_en,
  output logic             i_full_out,
  output logic [WIDTH-1:0] o_data_out,
  input  logic             o_read_en,
  output logic             o_empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Both pointers carry one extra MSB, the wrap bit. It tells full apart from empty
  // when the low bits of the two pointers are equal.
  always_comb begin
    o_empty_out = (wr_ptr == rd_ptr);
    i_full_out  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_acc      = i_write_en && !i_full_out;
    rd_acc      = o_read_en && !o_empty_out;
    o_data_out  = o_empty_out ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_acc) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Reset does not clear the storage array; the pointers alone define the valid contents.
  always_ff @(posedge clk) begin
    if (!clear && wr_acc) mem[wr_ptr[AW-1:0]] <= i_data_in;
  end

endmodule

// File: tb/tb_a_fifo.sv
// Self-checking bench for a_fifo. A queue-based reference model serves as the scoreboard.
// Accepted writes push to the queue; accepted reads pop and compare against the DUT head.
module tb_a_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             clear;
  logic [WIDTH-1:0] i_data_in;
  logic             i_write_en;
  logic             i_full_out;
  logic [WIDTH-1:0] o_data_out;
  logic             o_read_en;
  logic             o_empty_out;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [WIDTH-1:0] sb[$];

  a_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .i_data_in   (i_data_in),
    .i_write_en  (i_write_en),
    .i_full_out  (i_full_out),
    .o_data_out  (o_data_out),
    .o_read_en   (o_read_en),
    .o_empty_out (o_empty_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [WIDTH-1:0] head;
    head = (sb.size() > 0) ? sb[0] : '0;
    check({tag, "_empty"}, 32'(o_empty_out), 32'(sb.size() == 0));
    check({tag, "_full"},  32'(i_full_out),  32'(sb.size() == DEPTH));
    check({tag, "_data"},  32'(o_data_out),  32'(head));
  endtask

  // One clock cycle, starting and ending at a falling edge. The bench decides acceptance
  // from the model occupancy just before the rising edge.
  task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd,
                      input logic clr, input string tag);
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] exp;
    clear      = clr;
    i_write_en = wr;
    i_data_in  = wr ? d : 'x;
    o_read_en  = rd;
    wr_ok = wr && (sb.size() < DEPTH);
    rd_ok = rd && (sb.size() > 0);
    if (clr) begin
      sb.delete();
    end else begin
      if (rd_ok) begin
        exp = sb.pop_front();
        check({tag, "_pop"}, 32'(o_data_out), 32'(exp));
      end
      if (wr_ok) sb.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    clear      = 1'b1;
    i_write_en = 1'b0;
    o_read_en  = 1'b0;
    i_data_in  = '0;
    @(negedge clk);

    step(0, 0, 0, 1, "rst0");
    step(0, 0, 0, 1, "rst1");
    step(0, 0, 0, 0, "idle");

    step(1, 4'hA, 0, 0, "fill0");
    step(1, 4'hB, 0, 0, "fill1");
    step(1, 4'hC, 0, 0, "fill2");
    step(1, 4'hD, 0, 0, "fill3");

    step(1, 4'hE, 0, 0, "ovf");
    step(0, 0, 0, 0, "ovf_hold");

    for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 0, "drain");
    step(0, 0, 1, 0, "underflow");
    step(0, 0, 0, 0, "underflow_hold");

    step(1, 4'h1, 0, 0, "sim_pre0");
    step(1, 4'h2, 0, 0, "sim_pre1");
    for (int unsigned i = 0; i < 3; i++) step(1, 4'h5, 1, 0, "sim_rw");
    step(0, 0, 1, 0, "sim_drain0");
    step(0, 0, 1, 0, "sim_drain1");
    step(1, 4'h9, 1, 0, "sim_empty");
    step(0, 0, 1, 0, "sim_empty_rd");

    // Keep one word in flight while pushing and popping, so the pointers cross the wrap point.
    step(1, 4'h3, 0, 0, "wrap_pre");
    for (int unsigned i = 0; i < 10; i++) step(1, 4'(i + 6), 1, 0, "wrap");
    step(1, 4'hF, 1, 0, "wrap_full_rw");

    for (int unsigned i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 0, "rand");

    for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 0, "pre_clr_drain");
    step(1, 4'h7, 0, 0, "clr_pre0");
    step(1, 4'h8, 0, 0, "clr_pre1");
    step(1, 4'h6, 0, 0, "clr_pre2");
    step(1, 4'h4, 1, 1, "clr");
    step(0, 0, 1, 0, "post_clr_rd");
    step(1, 4'h2, 0, 0, "post_clr_wr");
    step(0, 0, 1, 0, "post_clr_pop");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
